// File: rtl/spi_receiver_if.sv
// spi_receiver_if: pin bundle between an SPI transmitter (master) and the receiver (slave)
interface spi_receiver_if;
   logic       CKP;
   logic       CPH;
   logic       SCK;
   logic       CS;
   logic       MOSI;
   logic [7:0] tx_data;
   logic       MISO;
   logic [7:0] data_out;
   logic       data_valid;
   logic       busy;
   modport master (output CKP, CPH, SCK, CS, MOSI, tx_data, input MISO, data_out, data_valid, busy);
   modport slave (input CKP, CPH, SCK, CS, MOSI, tx_data, output MISO, data_out, data_valid, busy);
endinterface

// File: rtl/spi_receiver.sv
// spi_receiver: oversampling SPI slave, all four modes, back-to-back bytes while CS stays low
module spi_receiver (
   input logic           clk,
   input logic           rst,
   spi_receiver_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, BYTE_DONE = 2'd2;
   logic [1:0] state_q, state_d;
   logic [2:0] sck_q, cs_q;
   logic [1:0] mosi_q;
   logic [1:0] mode_q, mode_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] rx_q, rx_d, tx_q, tx_d, dout_q, dout_d;
   logic       skip_q, skip_d;
   logic       rise, fall, lead, trail, samp, shft, cs_fall;
   // two-flop synchronizers; the third SCK/CS stage holds the previous synchronized value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_q  <= '0;
         cs_q   <= '0;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[1:0], bus.SCK};
         cs_q   <= {cs_q[1:0], bus.CS};
         mosi_q <= {mosi_q[0], bus.MOSI};
      end
   end
   // edge classification and frame/byte sequencing; skip_q holds bit 7 across the first shift edge of a byte
   always_comb begin
      rise    = sck_q[1] & ~sck_q[2];
      fall    = ~sck_q[1] & sck_q[2];
      lead    = mode_q[1] ? fall : rise;
      trail   = mode_q[1] ? rise : fall;
      samp    = mode_q[0] ? trail : lead;
      shft    = mode_q[0] ? lead : trail;
      cs_fall = ~cs_q[1] & cs_q[2];
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      dout_d  = dout_q;
      skip_d  = skip_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (cs_fall) begin
            state_d = ACTIVE;
            mode_d  = {bus.CKP, bus.CPH};
            tx_d    = bus.tx_data;
            skip_d  = bus.CPH;
         end
      end else if (state_q == ACTIVE) begin
         if (samp) begin
            rx_d  = {rx_q[6:0], mosi_q[1]};
            cnt_d = cnt_q + 3'd1;
         end
         if (shft) begin
            tx_d   = skip_q ? tx_q : {tx_q[6:0], 1'b0};
            skip_d = 1'b0;
         end
         if (samp && cnt_q == 3'd7) begin
            state_d = BYTE_DONE;
            dout_d  = rx_d;
            skip_d  = 1'b1;
         end else if (cs_q[1]) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end else begin
         tx_d    = bus.tx_data;
         state_d = cs_q[1] ? IDLE : ACTIVE;
      end
   end
   // state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         mode_q  <= '0;
         cnt_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         dout_q  <= '0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         dout_q  <= dout_d;
         skip_q  <= skip_d;
      end
   end
   assign bus.busy       = state_q != IDLE;
   assign bus.MISO       = bus.busy & tx_q[7];
   assign bus.data_valid = state_q == BYTE_DONE;
   assign bus.data_out   = dout_q;
endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: directed and randomized SPI frames against a queue-based model of received/returned bytes
module tb_spi_receiver;
   localparam int H = 63;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   logic [7:0] mb[4];
   logic [7:0] gb[4];
   logic [7:0] txe[4];
   logic [7:0] dv_q[$];
   logic [7:0] r;
   spi_receiver_if bus ();
   spi_receiver dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // every data_valid cycle records the byte presented
   always @(negedge clk) if (bus.data_valid === 1'b1) dv_q.push_back(bus.data_out);
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic spi_bits(input logic [1:0] mode, input logic [7:0] d, input int nb, output logic [7:0] rb);
      rb = '0;
      for (int i = 7; i > 7 - nb; i--) begin
         if (!mode[0]) begin
            bus.MOSI = d[i];
            #H;
            rb[i] = bus.MISO;
            bus.SCK = ~mode[1];
            #H;
            bus.SCK = mode[1];
         end else begin
            bus.SCK = ~mode[1];
            bus.MOSI = d[i];
            #H;
            rb[i] = bus.MISO;
            bus.SCK = mode[1];
            #H;
         end
      end
   endtask
   task automatic cs_low(input logic [1:0] mode);
      bus.CKP = mode[1];
      bus.CPH = mode[0];
      bus.SCK = mode[1];
      #(4 * H);
      bus.CS = 1'b0;
      bus.MOSI = 1'b0;
      #(2 * H);
   endtask
   task automatic cs_high();
      #(2 * H);
      bus.CS = 1'b1;
      #(4 * H);
   endtask
   task automatic run_frame(input logic [1:0] mode, input int n);
      cs_low(mode);
      check("busy_in_frame", bus.busy, 1'b1);
      for (int k = 0; k < n; k++) begin
         spi_bits(mode, mb[k], 8, r);
         gb[k] = r;
      end
      cs_high();
      check("busy_after", bus.busy, 1'b0);
      check("miso_after", bus.MISO, 1'b0);
   endtask
   task automatic expect_frame(input string tag, input int n);
      check({tag, "_dv_count"}, dv_q.size(), n);
      for (int k = 0; k < n; k++) begin
         if (dv_q.size() > 0) check({tag, "_rx"}, dv_q.pop_front(), mb[k]);
         check({tag, "_miso"}, gb[k], txe[k]);
      end
      dv_q.delete();
   endtask
   initial begin
      logic [1:0] m;
      int n;
      rst = 1'b0;
      bus.CS = 1'b1;
      bus.SCK = 1'b0;
      bus.MOSI = 1'b0;
      bus.CKP = 1'b0;
      bus.CPH = 1'b0;
      bus.tx_data = 8'h00;
      #23;
      check("rst_miso", bus.MISO, 1'b0);
      check("rst_dout", bus.data_out, 8'h00);
      check("rst_dv", bus.data_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      rst = 1'b1;
      #100;
      bus.tx_data = 8'h3C;
      mb[0] = 8'hA5;
      txe[0] = 8'h3C;
      run_frame(2'b00, 1);
      expect_frame("mode0", 1);
      for (int md = 1; md < 4; md++) begin
         bus.tx_data = 8'h69;
         mb[0] = 8'h96;
         txe[0] = 8'h69;
         run_frame(md[1:0], 1);
         expect_frame($sformatf("mode%0d", md), 1);
      end
      bus.tx_data = 8'h0F;
      mb[0] = 8'h12;
      mb[1] = 8'h34;
      txe[0] = 8'h0F;
      txe[1] = 8'hF0;
      fork
         begin
            do @(negedge clk); while (bus.data_valid !== 1'b1);
            bus.tx_data = 8'hF0;
         end
      join_none
      run_frame(2'b00, 2);
      expect_frame("b2b", 2);
      cs_low(2'b00);
      spi_bits(2'b00, 8'hFF, 5, r);
      cs_high();
      check("abort_dv", dv_q.size(), 0);
      check("abort_dout", bus.data_out, 8'h34);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_miso", bus.MISO, 1'b0);
      bus.tx_data = 8'hE1;
      mb[0] = 8'h5A;
      txe[0] = 8'hE1;
      run_frame(2'b00, 1);
      expect_frame("after_abort", 1);
      bus.tx_data = 8'hFF;
      cs_low(2'b00);
      spi_bits(2'b00, 8'hAA, 4, r);
      #7;
      rst = 1'b0;
      #1;
      check("arst_miso", bus.MISO, 1'b0);
      check("arst_dout", bus.data_out, 8'h00);
      check("arst_dv", bus.data_valid, 1'b0);
      check("arst_busy", bus.busy, 1'b0);
      #40;
      rst = 1'b1;
      #40;
      spi_bits(2'b00, 8'hFF, 8, r);
      #(4 * H);
      check("no_start_busy", bus.busy, 1'b0);
      check("no_start_dv", dv_q.size(), 0);
      cs_high();
      dv_q.delete();
      bus.tx_data = 8'h81;
      mb[0] = 8'hC3;
      txe[0] = 8'h81;
      run_frame(2'b00, 1);
      expect_frame("after_rst", 1);
      check("after_rst_dout", bus.data_out, 8'hC3);
      for (int t = 0; t < 16; t++) begin
         m = 2'($urandom_range(0, 3));
         n = $urandom_range(1, 3);
         bus.tx_data = 8'($urandom);
         for (int k = 0; k < n; k++) begin
            mb[k] = 8'($urandom);
            txe[k] = bus.tx_data;
         end
         run_frame(m, n);
         expect_frame("rand", n);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
